// File: rtl/datapath_fase_pkg.sv
// Shared constants and enums for the phase-2 multi-cycle datapath: opcodes,
// R-type function codes, ALU operation select and FSM state encoding.
package datapath_fase_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE, S_DECODE, S_EXEC, S_WB
  } state_t;

endpackage

// File: rtl/alu_fase.sv
// Combinational ALU for the phase-2 datapath. Shift operations are only
// selected by the decoder when SHIFT_OPS_EN is defined.
module alu_fase
  import datapath_fase_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  input  alu_op_t           alu_op,
  output logic [DATA_W-1:0] result
);

  logic shift_overflow;

  // Shift distances at or beyond the word width clear the result.
  assign shift_overflow = ({27'd0, shamt} >= 32'(DATA_W));

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: result = shift_overflow ? '0 : (b << shamt);
      ALU_SRL: result = shift_overflow ? '0 : (b >> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/datapath_fase_2.sv
// Multi-cycle MIPS-subset core: IDLE/DECODE/EXEC/WB FSM over an inline register
// file. Define SHIFT_OPS_EN to enable SLL/SRL (otherwise they decode as illegal).
module datapath_fase_2
  import datapath_fase_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clkFase,
  input  logic                  rstFase,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  illegal,
  output logic                  busy,
  input  logic [REG_ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0]     dbg_rdata
);

  localparam int NREG = 1 << REG_ADDR_W;

  state_t state_q, state_d;
  logic [31:0]           ir_q, ir_d;
  logic [DATA_W-1:0]     a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
  logic                  wb_valid_q, wb_valid_d, illegal_q, illegal_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic [DATA_W-1:0]     rf_q [NREG];

  logic [5:0]            op, funct;
  logic [4:0]            shamt;
  logic [REG_ADDR_W-1:0] rs_idx, rt_idx, rd_idx, dest;
  logic                  legal, use_imm, rf_we;
  alu_op_t               alu_op;
  logic [DATA_W-1:0]     imm_ext, alu_result;

  assign op     = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign shamt  = ir_q[10:6];
  assign rs_idx = ir_q[21 +: REG_ADDR_W];
  assign rt_idx = ir_q[16 +: REG_ADDR_W];
  assign rd_idx = ir_q[11 +: REG_ADDR_W];

  // Sign-extend the 16-bit immediate; narrow datapaths simply keep the low bits.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_sext
    if (gi < 16) begin : g_low
      assign imm_ext[gi] = ir_q[gi];
    end else begin : g_high
      assign imm_ext[gi] = ir_q[15];
    end
  end

  // Decode straight from IR; it stays stable from DECODE through WB.
  always_comb begin
    legal   = 1'b0;
    use_imm = 1'b0;
    alu_op  = ALU_ADD;
    dest    = rd_idx;
    case (op)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
`ifdef SHIFT_OPS_EN
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
`endif
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        legal   = 1'b1;
        use_imm = 1'b1;
        dest    = rt_idx;
      end
      default: legal = 1'b0;
    endcase
  end

  alu_fase #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .shamt  (shamt),
    .alu_op (alu_op),
    .result (alu_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXEC : S_IDLE;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_out_d  = alu_out_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    illegal_d  = 1'b0;
    rf_we      = 1'b0;
    case (state_q)
      S_IDLE: if (instr_valid) ir_d = instr;
      S_DECODE: begin
        a_d       = rf_q[rs_idx];
        b_d       = use_imm ? imm_ext : rf_q[rt_idx];
        illegal_d = !legal;
      end
      S_EXEC: alu_out_d = alu_result;
      S_WB: begin
        wb_valid_d = 1'b1;
        wb_addr_d  = dest;
        wb_data_d  = alu_out_q;
        rf_we      = (dest != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkFase or posedge rstFase) begin
    if (rstFase) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_out_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_out_q  <= alu_out_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
      if (rf_we) rf_q[dest] <= alu_out_q;
    end
  end

  assign instr_ready = (state_q == S_IDLE) && !rstFase;
  assign busy        = (state_q != S_IDLE);
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign illegal     = illegal_q;
  assign dbg_rdata   = (dbg_raddr == '0) ? '0 : rf_q[dbg_raddr];

endmodule
